// File: rtl/mealy_seq_10110_ov.sv
// +----------------------------------------------------------------------------+
// | Module      : mealy_seq_10110_ov                                            |
// | Description : Overlapping Mealy detector for serial pattern 1-0-1-1-0.      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module mealy_seq_10110_ov (
   input  logic in_seq,
   input  logic clk,
   input  logic rst,
   output logic det_out
);

   // Each state is the longest suffix of received bits that prefixes 10110.
   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      S1    = 3'b001,
      S10   = 3'b010,
      S101  = 3'b011,
      S1011 = 3'b100
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   w_det;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = IDLE;
      w_det  = 1'b0;
      case (r_state)
         IDLE:    w_next = in_seq ? S1 : IDLE;
         S1:      w_next = in_seq ? S1 : S10;
         S10:     w_next = in_seq ? S101 : IDLE;
         S101:    w_next = in_seq ? S1011 : S10;
         S1011: begin
            // On a hit the trailing "10" is kept so overlapping matches are seen.
            w_next = in_seq ? S1 : S10;
            w_det  = ~in_seq;
         end
         default: w_next = IDLE;
      endcase
   end

   assign det_out = w_det;

endmodule

`default_nettype wire

// File: tb/tb_mealy_seq_10110_ov.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_mealy_seq_10110_ov                                         |
// | Description : Directed and random self-checking bench for the detector.     |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mealy_seq_10110_ov;

   logic clk;
   logic rst;
   logic in_seq;
   logic det_out;

   int n_chk;
   int n_pass;

   logic [3:0] m_hist;

   mealy_seq_10110_ov dut (
      .in_seq  (in_seq),
      .clk     (clk),
      .rst     (rst),
      .det_out (det_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: last four accepted bits, cleared by reset.
   always @(posedge clk or negedge rst) begin
      if (!rst) m_hist <= 4'b0000;
      else      m_hist <= {m_hist[2:0], in_seq};
   end

   task automatic check(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic check_st(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   // Drive one bit just after an edge, sample just before the next edge.
   task automatic bit_step(input logic b, input logic exp, input string tag);
      @(posedge clk);
      #1 in_seq = b;
      #8;
      check(tag, det_out, exp);
      check({tag, "_model"}, det_out, (m_hist == 4'b1011) && !b);
   endtask

   task automatic run_vec(input string tag, input int n,
                          input logic [15:0] bits, input logic [15:0] hits);
      for (int i = 0; i < n; i++) begin
         bit_step(bits[n-1-i], hits[n-1-i], $sformatf("%s_b%0d", tag, i + 1));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic b;
      n_chk  = 0;
      n_pass = 0;
      rst    = 1'b0;
      in_seq = 1'b0;

      // 1) reset held with toggling input
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1 in_seq = ~in_seq;
         #8;
         check("rst_det", det_out, 1'b0);
         check_st("rst_state", dut.r_state, 3'b000);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      in_seq = 1'b0;

      // 2) single pattern
      run_vec("t2", 5, 16'b10110, 16'b00001);
      @(posedge clk);
      #1 check_st("t2_state", dut.r_state, 3'b010);
      in_seq = 1'b0;
      #8 check("t2_gap", det_out, 1'b0);
      bit_step(1'b0, 1'b0, "gap2");

      // 3) two back-to-back patterns
      run_vec("t3", 10, 16'b1011010110, 16'b0000100001);
      bit_step(1'b0, 1'b0, "gap3");

      // 4) overlapping patterns
      run_vec("t4", 8, 16'b10110110, 16'b00001001);
      bit_step(1'b0, 1'b0, "gap4");

      // 5) near-misses, no complete 10110 anywhere
      run_vec("t5", 12, 16'b110111001010, 16'b000000000000);
      bit_step(1'b0, 1'b0, "gap5a");
      bit_step(1'b0, 1'b0, "gap5b");

      // 6) asynchronous reset discards partial progress
      run_vec("t6", 4, 16'b1011, 16'b0000);
      @(posedge clk);
      #1 in_seq = 1'b1;
      #2 rst = 1'b0;
      #1;
      check_st("t6_async_state", dut.r_state, 3'b000);
      check("t6_async_det", det_out, 1'b0);
      #1 rst = 1'b1;
      #1 in_seq = 1'b0;
      #3;
      check("t6_after_det", det_out, 1'b0);
      check("t6_after_model", det_out, (m_hist == 4'b1011) && !in_seq);
      @(posedge clk);
      #1 check_st("t6_restart_state", dut.r_state, 3'b000);

      // Random bits against the reference
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1 b = 1'($urandom_range(0, 1));
         in_seq = b;
         #8;
         check($sformatf("rand_%0d", i), det_out, (m_hist == 4'b1011) && !b);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
